// File: rtl/sha256_pkg.sv
// Shared SHA-256 types, block/round constants and the message-schedule sigma functions.
// Reused by the message scheduler and the compression core.
package sha256_pkg;

    typedef logic [31:0] word_t;

    localparam int unsigned BLOCK_WORDS = 16;
    localparam int unsigned ROUNDS      = 64;

    typedef enum logic {StLoad, StEmit} sched_state_e;

    // sigma0(x) = ROTR7 ^ ROTR18 ^ SHR3
    function automatic word_t sigma0(input word_t x);
        return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ {3'b000, x[31:3]};
    endfunction

    // sigma1(x) = ROTR17 ^ ROTR19 ^ SHR10
    function automatic word_t sigma1(input word_t x);
        return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ {10'b0, x[31:10]};
    endfunction

endpackage

// File: rtl/sha256_msg_schedule.sv
// SHA-256 message schedule: loads 16 message words into a sliding window, then streams
// W[0..63] to the compression core with a valid/ready handshake.
module sha256_msg_schedule
    import sha256_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       abort,
    input  logic       in_valid,
    output logic       in_ready,
    input  word_t      in_word,
    output logic       w_valid,
    input  logic       w_ready,
    output word_t      w_word,
    output logic [5:0] w_idx,
    output logic       w_last
);

    sched_state_e state_q, state_d;
    logic [3:0]   load_cnt_q, load_cnt_d;
    logic [5:0]   t_q, t_d;
    word_t        window_q [BLOCK_WORDS];
    word_t        window_d [BLOCK_WORDS];
    word_t        next_word;

    always_comb begin
        state_d    = state_q;
        load_cnt_d = load_cnt_q;
        t_d        = t_q;
        window_d   = window_q;

        in_ready = (state_q == StLoad);
        w_valid  = (state_q == StEmit);
        w_word   = window_q[0];
        w_idx    = t_q;
        w_last   = (state_q == StEmit) && (t_q == 6'(ROUNDS - 1));

        // Values shifted in after t = 47 are never emitted; no need to suppress them.
        next_word = sigma1(window_q[14]) + window_q[9] + sigma0(window_q[1]) + window_q[0];

        if (abort) begin
            state_d    = StLoad;
            load_cnt_d = 4'd0;
            t_d        = 6'd0;
        end else begin
            unique case (state_q)
                StLoad: begin
                    if (in_valid) begin
                        window_d[load_cnt_q] = in_word;
                        load_cnt_d           = load_cnt_q + 4'd1;
                        if (load_cnt_q == 4'(BLOCK_WORDS - 1)) begin
                            state_d = StEmit;
                            t_d     = 6'd0;
                        end
                    end
                end
                StEmit: begin
                    if (w_ready) begin
                        for (int i = 0; i < BLOCK_WORDS - 1; i++) begin
                            window_d[i] = window_q[i+1];
                        end
                        window_d[BLOCK_WORDS-1] = next_word;
                        t_d                     = t_q + 6'd1;
                        if (t_q == 6'(ROUNDS - 1)) begin
                            state_d    = StLoad;
                            load_cnt_d = 4'd0;
                        end
                    end
                end
                default: state_d = StLoad;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StLoad;
            load_cnt_q <= 4'd0;
            t_q        <= 6'd0;
            window_q   <= '{default: '0};
        end else begin
            state_q    <= state_d;
            load_cnt_q <= load_cnt_d;
            t_q        <= t_d;
            window_q   <= window_d;
        end
    end

endmodule

// File: doc/sha256_msg_schedule.md
SHA256_MSG_SCHEDULE -- requirements
Module: sha256_msg_schedule

Interface
REQ-001 The block SHALL have no parameters; word width (32), block size (16 words) and round count (64) are fixed constants.
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 abort  input  1  synchronous clear of the current block; returns to LOAD.
REQ-005 in_valid  input  1  upstream message word valid.
REQ-006 in_ready  output  1  block can accept a message word.
REQ-007 in_word  input  32  message word M[i], big-endian order, i = 0..15.
REQ-008 w_valid  output  1  schedule word W[t] valid toward compression core.
REQ-009 w_ready  input  1  compression core accepts W[t].
REQ-010 w_word  output  32  schedule word W[t].
REQ-011 w_idx  output  6  round index t, 0..63.
REQ-012 w_last  output  1  high with w_valid when t = 63.

Function
REQ-013 FSM states: LOAD and EMIT; no other states.
REQ-014 LOAD: in_ready = 1, w_valid = 0; word accepted when in_valid && in_ready; 4-bit load counter increments per accept.
REQ-015 Accepted words fill a 16x32 window in order; slot 0 holds M[0].
REQ-016 On the 16th accept (counter = 15), the FSM enters EMIT the next cycle with counter = 0; w_valid rises in that cycle (latency 1 cycle from last accept).
REQ-017 EMIT: in_ready = 0, w_valid = 1, w_word = window[0], w_idx = t.
REQ-018 W[t] transfers when w_valid && w_ready; t then increments and the window shifts one slot toward 0.
REQ-019 Shifted-in word = sigma1(window[14]) + window[9] + sigma0(window[1]) + window[0], modulo 2^32; carries discarded.
REQ-020 sigma0(x) = ROTR7 ^ ROTR18 ^ SHR3; sigma1(x) = ROTR17 ^ ROTR19 ^ SHR10.
REQ-021 While w_valid && !w_ready, w_word, w_idx and w_last SHALL hold stable; the window SHALL NOT shift.
REQ-022 Transfer at t = 63 returns the FSM to LOAD the next cycle; in_ready = 1 and the load counter = 0 in that cycle.
REQ-023 Shifted-in values after t = 47 are don't-care, but the emitted W[48..63] SHALL be correct.
REQ-024 abort has priority over all handshakes in every state: the next cycle is LOAD with counter 0, t = 0 and w_valid = 0; a word presented with abort is discarded.
REQ-025 in_valid during EMIT SHALL be ignored and cause no state change.
REQ-026 No back-to-back overlap: the next block loads only after W[63] transfers.

Reset
REQ-027 While rst_n = 0, the state is forced to LOAD, load counter = 0, t = 0, w_valid = 0, w_word = 0, w_idx = 0, w_last = 0, in_ready = 1 and window = 0.
REQ-028 Reset is effective immediately (asynchronous); release is synchronous to clk by the surrounding reset synchronizer.
REQ-029 Reset mid-EMIT discards the block; no partial output follows.

Structure
REQ-030 Shared package sha256_pkg holds: 32-bit word typedef, constants BLOCK_WORDS = 16 and ROUNDS = 64, and the sigma0/sigma1 functions (reused by the compression core).
REQ-031 The block SHALL be single-level with no sub-module; the window and FSM live in sha256_msg_schedule.

Verification
REQ-032 "abc" block (M0 = 0x61626380, M1..M14 = 0, M15 = 0x00000018), w_ready = 1 -> W16 = 0x61626380, W17 = 0x000F0000, W63 = 0x12B1EDEB; w_last only at w_idx = 63; in_ready = 1 the cycle after.
REQ-033 Same block with w_ready toggled randomly at 50% -> identical W[0..63] sequence; outputs stable during each stall.
REQ-034 in_valid held high across the full load and EMIT -> exactly 16 words consumed; in_ready = 0 for all 64 EMIT cycles.
REQ-035 abort asserted at t = 20 with w_ready = 0 -> next cycle w_valid = 0, in_ready = 1; a fresh "abc" block then yields W16 = 0x61626380.
REQ-036 rst_n pulsed low after 7 loaded words -> all outputs at reset values immediately; the following 16-word load produces the correct schedule.
REQ-037 All-ones block (M[i] = 0xFFFFFFFF) -> every W[t] matches a reference model modulo 2^32, checking carry discard.
